// File: rtl/mig_pkg.sv
// Shared types and constants for the MIG truth-table simulator.
// Optional checker port set is enabled by MIG_TT_SIM_CHECK_EN.
package mig_pkg;

  localparam int NODE_W     = 4;
  localparam int FIRST_GATE = 5;

  localparam logic [15:0] TT_X0 = 16'hAAAA;
  localparam logic [15:0] TT_X1 = 16'hCCCC;
  localparam logic [15:0] TT_X2 = 16'hF0F0;
  localparam logic [15:0] TT_X3 = 16'hFF00;

  typedef enum logic {
    ST_LOAD,
    ST_DONE
  } st_t;

  typedef struct packed {
    logic [NODE_W-1:0] fc;
    logic [NODE_W-1:0] fb;
    logic [NODE_W-1:0] fa;
    logic [2:0]        cmp;
    logic              last;
    logic              ocmp;
  } gate_t;

  // Fixed nodes: constant 0 and the four input projections.
  function automatic logic [15:0] fixed_tt(
    input logic [NODE_W-1:0] idx
  );
    logic [15:0] v;
    v = 16'h0000;
    unique case (1'b1)
      (idx == 4'd1): v = TT_X0;
      (idx == 4'd2): v = TT_X1;
      (idx == 4'd3): v = TT_X2;
      (idx == 4'd4): v = TT_X3;
      default:       v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mig_maj16.sv
// Combinational 16-bit majority with per-operand inversion.
// cmp = {c, b, a}.
module mig_maj16
  import mig_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_c,
  input  logic [2:0]  i_cmp,
  output logic [15:0] o_y
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_c;

  assign w_a = i_a ^ {16{i_cmp[0]}};
  assign w_b = i_b ^ {16{i_cmp[1]}};
  assign w_c = i_c ^ {16{i_cmp[2]}};

  assign o_y = (w_a & w_b)
             | (w_a & w_c)
             | (w_b & w_c);

endmodule

// File: rtl/mig_tt_sim.sv
// Streams MIG gate descriptors and returns the output truth table.
// Define MIG_TT_SIM_CHECK_EN to add s_exp / m_match.
module mig_tt_sim
  import mig_pkg::*;
#(
  parameter int MAX_GATES = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_fin,
  input  logic [2:0]  s_cmp,
  input  logic        s_last,
  input  logic        s_ocmp,
`ifdef MIG_TT_SIM_CHECK_EN
  input  logic [15:0] s_exp,
`endif
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_tt,
`ifdef MIG_TT_SIM_CHECK_EN
  output logic        m_match,
`endif
  output logic        m_err
);

  localparam logic [4:0] NXT0 = 5'(FIRST_GATE);
  localparam logic [4:0] LIM  =
    5'(FIRST_GATE + MAX_GATES);

  st_t         r_st;
  logic [4:0]  r_nxt;
  logic        r_err;
  logic        r_s_ready;
  logic        r_m_valid;
  logic [15:0] r_m_tt;
  logic        r_m_err;
  logic [15:0] r_node [FIRST_GATE:15];

  gate_t       w_g;
  logic        w_hs;
  logic        w_ovf;
  logic        w_fwd;
  logic        w_err;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_c;
  logic [15:0] w_y;
  logic [15:0] w_res;

  assign w_g = '{
    fc:   s_fin[11:8],
    fb:   s_fin[7:4],
    fa:   s_fin[3:0],
    cmp:  s_cmp,
    last: s_last,
    ocmp: s_ocmp
  };

  // Registered nodes give the old value on a same-cycle read.
  function automatic logic [15:0] rd(
    input logic [NODE_W-1:0] idx
  );
    logic [15:0] v;
    if (idx < 4'(FIRST_GATE)) v = fixed_tt(idx);
    else                      v = r_node[idx];
    return v;
  endfunction

  assign w_a = rd(w_g.fa);
  assign w_b = rd(w_g.fb);
  assign w_c = rd(w_g.fc);

  mig_maj16 u_maj (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_c   (w_c),
    .i_cmp (w_g.cmp),
    .o_y   (w_y)
  );

  assign w_hs  = s_valid & r_s_ready;
  assign w_ovf = (r_nxt == LIM);
  assign w_fwd = ({1'b0, w_g.fa} >= r_nxt)
               | ({1'b0, w_g.fb} >= r_nxt)
               | ({1'b0, w_g.fc} >= r_nxt);
  assign w_err = r_err | w_ovf | w_fwd;
  assign w_res = w_err ? 16'h0000
               : (w_y ^ {16{w_g.ocmp}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = FIRST_GATE; k < 16; k++)
        r_node[k] <= 16'h0000;
    end else if (w_hs && !w_ovf) begin
      r_node[r_nxt[3:0]] <= w_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= ST_LOAD;
      r_nxt     <= NXT0;
      r_err     <= 1'b0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_tt    <= 16'h0000;
      r_m_err   <= 1'b0;
    end else begin
      unique case (r_st)
        ST_LOAD: begin
          if (w_hs) begin
            if (!w_ovf) r_nxt <= r_nxt + 5'd1;
            r_err <= w_err;
            if (w_g.last) begin
              r_st      <= ST_DONE;
              r_s_ready <= 1'b0;
              r_m_valid <= 1'b1;
              r_m_tt    <= w_res;
              r_m_err   <= w_err;
            end
          end
        end
        ST_DONE: begin
          if (m_ready) begin
            r_st      <= ST_LOAD;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_nxt     <= NXT0;
            r_err     <= 1'b0;
          end
        end
        default: r_st <= ST_LOAD;
      endcase
    end
  end

`ifdef MIG_TT_SIM_CHECK_EN
  logic r_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
    end else if (w_hs && w_g.last
                 && r_st == ST_LOAD) begin
      r_match <= !w_err && (w_res == s_exp);
    end
  end

  assign m_match = r_match;
`endif

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_tt    = r_m_tt;
  assign m_err   = r_m_err;

endmodule

// File: tb/tb_mig_tt_sim.sv
// Directed bench for mig_tt_sim with a netlist-level reference model.
// Build with MIG_TT_SIM_CHECK_EN to also check m_match.
module tb_mig_tt_sim;
  import mig_pkg::*;

  localparam int MAXG = 11;

  typedef struct packed {
    logic [15:0] tt;
    logic        err;
    logic        match;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_fin = '0;
  logic [2:0]  s_cmp = '0;
  logic        s_last = 1'b0;
  logic        s_ocmp = 1'b0;
  logic [15:0] s_exp = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_tt;
  logic        m_match;
  logic        m_err;

  int   n_chk = 0;
  int   n_err = 0;
  gate_t net[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  mig_tt_sim #(.MAX_GATES(MAXG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_fin   (s_fin),
    .s_cmp   (s_cmp),
    .s_last  (s_last),
    .s_ocmp  (s_ocmp),
`ifdef MIG_TT_SIM_CHECK_EN
    .s_exp   (s_exp),
    .m_match (m_match),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_tt    (m_tt),
    .m_err   (m_err)
  );

`ifndef MIG_TT_SIM_CHECK_EN
  assign m_match = 1'b0;
`endif

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h t=%0t",
               nm, got, want, $time);
    end
  endtask

  task automatic add(input logic [3:0] c,
                     input logic [3:0] b,
                     input logic [3:0] a,
                     input logic [2:0] cm,
                     input logic oc);
    net.push_back('{fc: c, fb: b, fa: a, cmp: cm,
                    last: 1'b0, ocmp: oc});
  endtask

  // Netlist-level reference: evaluate each gate in order.
  function automatic void model(
    input  logic [15:0] sexp,
    output logic [15:0] tt,
    output logic        er,
    output logic        mt
  );
    logic [15:0] nd [16];
    logic [15:0] v  [3];
    logic [3:0]  f  [3];
    int          n;
    logic        oc;
    n  = 5;
    oc = 1'b0;
    er = 1'b0;
    foreach (nd[k]) nd[k] = 16'h0000;
    nd[1] = 16'hAAAA; nd[2] = 16'hCCCC;
    nd[3] = 16'hF0F0; nd[4] = 16'hFF00;
    foreach (net[i]) begin
      oc = net[i].ocmp;
      if (n == 5 + MAXG) begin
        er = 1'b1;
        continue;
      end
      f = '{net[i].fa, net[i].fb, net[i].fc};
      for (int j = 0; j < 3; j++) begin
        if (int'(f[j]) >= n) er = 1'b1;
        v[j] = nd[f[j]] ^ {16{net[i].cmp[j]}};
      end
      nd[n] = (v[0] & v[1]) | (v[0] & v[2])
            | (v[1] & v[2]);
      n++;
    end
    tt = er ? 16'h0000 : (nd[n-1] ^ {16{oc}});
    mt = !er && (tt == sexp);
  endfunction

  task automatic drive(input int i);
    s_valid = 1'b1;
    s_fin   = {net[i].fc, net[i].fb, net[i].fa};
    s_cmp   = net[i].cmp;
    s_ocmp  = net[i].ocmp;
    s_last  = (i == net.size() - 1);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [15:0] lit_tt,
                     input logic lit_err,
                     input logic [15:0] sexp,
                     input logic lit_match,
                     input int hold);
    logic [15:0] mtt;
    logic mer, mmt;
    int n;
    model(sexp, mtt, mer, mmt);
    chk("model_tt", 32'(mtt), 32'(lit_tt));
    chk("model_err", 32'(mer), 32'(lit_err));
    chk("model_match", 32'(mmt), 32'(lit_match));
    exp_q.push_back('{tt: mtt, err: mer, match: mmt});
    s_exp = sexp;
    n = 0;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(s_ready), 32'd1);
    foreach (net[i]) drive(i);
    chk("latency_valid", 32'(m_valid), 32'd1);
    // Junk beat while DONE must be ignored.
    s_fin  = 12'h000;
    s_cmp  = 3'b111;
    s_last = 1'b1;
    m_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk("hold_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("post_hs_valid", 32'(m_valid), 32'd0);
    chk("post_hs_ready", 32'(s_ready), 32'd1);
    net.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_tt"}, 32'(m_tt), 32'd0);
    chk({tag, "_m_err"}, 32'(m_err), 32'd0);
`ifdef MIG_TT_SIM_CHECK_EN
    chk({tag, "_m_match"}, 32'(m_match), 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_valid", 32'(s_ready),
          32'(!m_valid));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("m_tt", 32'(m_tt), 32'(exp_q[0].tt));
          chk("m_err", 32'(m_err), 32'(exp_q[0].err));
`ifdef MIG_TT_SIM_CHECK_EN
          chk("m_match", 32'(m_match),
              32'(exp_q[0].match));
`endif
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=done");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    add(0, 2, 1, 3'b000, 1'b0);
    run(16'h8888, 1'b0, 16'h8888, 1'b1, 0);
    add(0, 2, 1, 3'b000, 1'b0);
    run(16'h8888, 1'b0, 16'h8889, 1'b0, 3);
    add(0, 2, 1, 3'b100, 1'b1);
    run(16'h1111, 1'b0, 16'h1111, 1'b1, 1);
    add(3, 2, 1, 3'b000, 1'b0);
    run(16'hE8E8, 1'b0, 16'hE8E8, 1'b1, 0);
    add(3, 2, 1, 3'b000, 1'b0);
    add(5, 0, 4, 3'b010, 1'b0);
    run(16'hFFE8, 1'b0, 16'h0000, 1'b0, 2);

    add(6, 1, 2, 3'b000, 1'b0);
    run(16'h0000, 1'b1, 16'h0000, 1'b0, 0);
    add(0, 2, 1, 3'b000, 1'b0);
    run(16'h8888, 1'b0, 16'h8888, 1'b1, 0);
    add(0, 1, 5, 3'b000, 1'b0);
    run(16'h0000, 1'b1, 16'h1234, 1'b0, 1);

    for (int i = 0; i <= MAXG; i++)
      add(0, 2, 1, 3'b000, 1'b0);
    run(16'h0000, 1'b1, 16'h8888, 1'b0, 0);
    add(0, 2, 1, 3'b000, 1'b0);
    for (int i = 1; i < MAXG; i++)
      add(4'(4 + i), 0, 4'(4 + i), 3'b000,
          i == MAXG - 1);
    run(16'h7777, 1'b0, 16'h7777, 1'b1, 0);

    add(3, 2, 1, 3'b000, 1'b0);
    add(5, 0, 4, 3'b010, 1'b0);
    add(0, 1, 6, 3'b000, 1'b0);
    add(0, 7, 7, 3'b011, 1'b0);
    drive(0);
    drive(1);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(16'h5557, 1'b0, 16'h5557, 1'b1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
